main_ctrl_fsm: RTL and testbench

MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

---
 rtl/main_ctrl_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_main_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm
//   Multi-cycle MIPS-style main control unit. Sequences fetch, decode and the
//   per-class execute/memory/write-back steps for R-type, LW, SW, BEQ and J.
//   Flags any other opcode as illegal (sticky) and counts retired instructions.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   opcode    in   [5:0] instruction register bits [31:26]
//   zero      in   ALU zero flag (branch condition)
//   mem_ack   in   memory transfer complete
//   mem_req   out  memory access request
//   memwrite  out  write qualifier for mem_req
//   iord      out  address select: 0=PC, 1=ALUOut
//   irwrite   out  instruction register load enable
//   pc_en     out  PC load enable
//   pcsrc     out  [1:0] 00=ALU, 01=ALUOut, 10=jump target
//   alusrca   out  0=PC, 1=register A
//   alusrcb   out  [1:0] 00=B, 01=4, 10=sign-ext imm, 11=shifted imm
//   aluop     out  [1:0] 00=add, 01=subtract, 10=funct-decoded
//   regdst    out  register-file destination select
//   memtoreg  out  register-file write data select
//   regwrite  out  register-file write enable
//   illegal   out  sticky unsupported-opcode flag
//   retired   out  [15:0] completed-instruction count (wraps)
//   state     out  [3:0] current state code
module main_ctrl_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        memwrite,
   output logic        iord,
   output logic        irwrite,
   output logic        pc_en,
   output logic [1:0]  pcsrc,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  aluop,
   output logic        regdst,
   output logic        memtoreg,
   output logic        regwrite,
   output logic        illegal,
   output logic [15:0] retired,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StMemAdr = 4'd3,
      StMemRd  = 4'd4,
      StMemWb  = 4'd5,
      StMemWr  = 4'd6,
      StExec   = 4'd7,
      StRwb    = 4'd8,
      StBranch = 4'd9,
      StJump   = 4'd10
   } state_t;

   state_t      state_q, state_d;
   logic        illegal_q;
   logic [15:0] retired_q;
   logic        illegal_set;
   logic        retire;

   // Next-state, illegal detection and retire strobe.
   always_comb begin
      state_d     = state_q;
      illegal_set = 1'b0;
      retire      = 1'b0;
      case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  if (mem_ack) state_d = StDecode;
         StDecode: begin
            if (opcode == OP_LW || opcode == OP_SW) begin
               state_d = StMemAdr;
            end else if (opcode == OP_RTYPE) begin
               state_d = StExec;
            end else if (opcode == OP_BEQ) begin
               state_d = StBranch;
            end else if (opcode == OP_J) begin
               state_d = StJump;
            end else begin
               state_d     = StFetch;
               illegal_set = 1'b1;
            end
         end
         StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
         StMemRd:  if (mem_ack) state_d = StMemWb;
         StMemWr: begin
            if (mem_ack) begin
               state_d = StFetch;
               retire  = 1'b1;
            end
         end
         StMemWb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StExec:   state_d = StRwb;
         StRwb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StBranch: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StJump: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         // Unused codes 11-15 recover through FETCH.
         default:  state_d = StFetch;
      endcase
   end

   // State, sticky flag, counter and Moore outputs. The Moore outputs are
   // decoded from state_d so they line up with state_q without a cycle of lag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         illegal_q <= 1'b0;
         retired_q <= 16'h0000;
         mem_req   <= 1'b0;
         memwrite  <= 1'b0;
         iord      <= 1'b0;
         pcsrc     <= 2'b00;
         alusrca   <= 1'b0;
         alusrcb   <= 2'b00;
         aluop     <= 2'b00;
         regdst    <= 1'b0;
         memtoreg  <= 1'b0;
         regwrite  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (illegal_set) illegal_q <= 1'b1;
         if (retire)      retired_q <= retired_q + 16'd1;

         mem_req  <= 1'b0;
         memwrite <= 1'b0;
         iord     <= 1'b0;
         pcsrc    <= 2'b00;
         alusrca  <= 1'b0;
         alusrcb  <= 2'b00;
         aluop    <= 2'b00;
         regdst   <= 1'b0;
         memtoreg <= 1'b0;
         regwrite <= 1'b0;
         case (state_d)
            StFetch: begin
               mem_req <= 1'b1;
               alusrcb <= 2'b01;
            end
            StDecode: alusrcb <= 2'b11;
            StMemAdr: begin
               alusrca <= 1'b1;
               alusrcb <= 2'b10;
            end
            StMemRd: begin
               mem_req <= 1'b1;
               iord    <= 1'b1;
            end
            StMemWr: begin
               mem_req  <= 1'b1;
               iord     <= 1'b1;
               memwrite <= 1'b1;
            end
            StMemWb: begin
               memtoreg <= 1'b1;
               regwrite <= 1'b1;
            end
            StExec: begin
               alusrca <= 1'b1;
               aluop   <= 2'b10;
            end
            StRwb: begin
               regdst   <= 1'b1;
               regwrite <= 1'b1;
            end
            StBranch: begin
               alusrca <= 1'b1;
               aluop   <= 2'b01;
               pcsrc   <= 2'b01;
            end
            StJump:   pcsrc <= 2'b10;
            default: ;
         endcase
      end
   end

   // Handshake- and condition-qualified strobes; state_q is reset
   // asynchronously so these drop immediately on rst.
   assign irwrite = (state_q == StFetch) && mem_ack;
   assign pc_en   = ((state_q == StFetch) && mem_ack)
                  || ((state_q == StBranch) && zero)
                  || (state_q == StJump);

   assign illegal = illegal_q;
   assign retired = retired_q;
   assign state   = state_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: walks LW, R-type, BEQ (taken/not taken),
// an illegal opcode, reset during a store handshake and the counter wrap.
module tb_main_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ack;
   logic        mem_req, memwrite, iord, irwrite, pc_en;
   logic [1:0]  pcsrc, alusrcb, aluop;
   logic        alusrca, regdst, memtoreg, regwrite, illegal;
   logic [15:0] retired;
   logic [3:0]  state;

   int errors = 0;
   int checks = 0;
   int rw_pulses = 0;

   main_ctrl_fsm dut (
      .clk      (clk),
      .rst      (rst),
      .opcode   (opcode),
      .zero     (zero),
      .mem_ack  (mem_ack),
      .mem_req  (mem_req),
      .memwrite (memwrite),
      .iord     (iord),
      .irwrite  (irwrite),
      .pc_en    (pc_en),
      .pcsrc    (pcsrc),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .aluop    (aluop),
      .regdst   (regdst),
      .memtoreg (memtoreg),
      .regwrite (regwrite),
      .illegal  (illegal),
      .retired  (retired),
      .state    (state)
   );

   always #5 clk = ~clk;

   // Count cycles in which a register write is presented to the register file.
   always @(posedge clk) if (regwrite === 1'b1) rw_pulses++;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; land 2 time units after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst     = 1'b1;
      opcode  = 6'b100011;
      zero    = 1'b0;
      mem_ack = 1'b0;
      #12;
      chk("rst_state",   16'(state),   16'd0);
      chk("rst_retired", retired,      16'h0000);
      chk("rst_illegal", 16'(illegal), 16'd0);
      chk("rst_mem_req", 16'(mem_req), 16'd0);
      chk("rst_pc_en",   16'(pc_en),   16'd0);

      // LW with ack on the 3rd cycle of each request.
      rst = 1'b0;
      #1;
      chk("idle_state", 16'(state), 16'd0);
      cyc();
      chk("fetch1_state",   16'(state),   16'd1);
      chk("fetch1_mem_req", 16'(mem_req), 16'd1);
      chk("fetch1_alusrcb", 16'(alusrcb), 16'd1);
      chk("fetch1_irwrite", 16'(irwrite), 16'd0);
      cyc();
      chk("fetch2_state", 16'(state), 16'd1);
      cyc();
      mem_ack = 1'b1;
      #1;
      chk("fetch3_irwrite", 16'(irwrite), 16'd1);
      chk("fetch3_pc_en",   16'(pc_en),   16'd1);
      cyc();
      mem_ack = 1'b0;
      chk("lw_decode_state",   16'(state),   16'd2);
      chk("lw_decode_alusrcb", 16'(alusrcb), 16'd3);
      chk("lw_decode_mem_req", 16'(mem_req), 16'd0);
      cyc();
      chk("lw_memadr_state",   16'(state),   16'd3);
      chk("lw_memadr_alusrca", 16'(alusrca), 16'd1);
      chk("lw_memadr_alusrcb", 16'(alusrcb), 16'd2);
      cyc();
      chk("lw_memrd_state",    16'(state),    16'd4);
      chk("lw_memrd_iord",     16'(iord),     16'd1);
      chk("lw_memrd_memwrite", 16'(memwrite), 16'd0);
      cyc();
      chk("lw_memrd2_mem_req", 16'(mem_req), 16'd1);
      cyc();
      mem_ack = 1'b1;
      chk("lw_memrd3_state", 16'(state), 16'd4);
      cyc();
      mem_ack = 1'b0;
      chk("lw_memwb_state",    16'(state),    16'd5);
      chk("lw_memwb_regwrite", 16'(regwrite), 16'd1);
      chk("lw_memwb_memtoreg", 16'(memtoreg), 16'd1);
      chk("lw_memwb_regdst",   16'(regdst),   16'd0);
      chk("lw_memwb_retired",  retired,       16'd0);
      cyc();
      chk("lw_done_state",   16'(state), 16'd1);
      chk("lw_done_retired", retired,    16'd1);
      chk("lw_rw_pulses",    16'(rw_pulses), 16'd1);

      // R-type, ack tied high: FETCH, DECODE, EXEC, RWB.
      opcode  = 6'b000000;
      mem_ack = 1'b1;
      cyc();
      chk("r_decode_state", 16'(state), 16'd2);
      cyc();
      chk("r_exec_state",   16'(state),   16'd7);
      chk("r_exec_aluop",   16'(aluop),   16'd2);
      chk("r_exec_alusrca", 16'(alusrca), 16'd1);
      chk("r_exec_mem_req", 16'(mem_req), 16'd0);
      cyc();
      chk("r_rwb_state",    16'(state),    16'd8);
      chk("r_rwb_regdst",   16'(regdst),   16'd1);
      chk("r_rwb_regwrite", 16'(regwrite), 16'd1);
      cyc();
      chk("r_done_state",   16'(state), 16'd1);
      chk("r_done_retired", retired,    16'd2);

      // BEQ taken then not taken.
      opcode = 6'b000100;
      zero   = 1'b1;
      cyc();
      cyc();
      chk("beq1_state", 16'(state), 16'd9);
      chk("beq1_pc_en", 16'(pc_en), 16'd1);
      chk("beq1_pcsrc", 16'(pcsrc), 16'd1);
      chk("beq1_aluop", 16'(aluop), 16'd1);
      cyc();
      chk("beq1_retired", retired, 16'd3);
      zero = 1'b0;
      cyc();
      cyc();
      chk("beq0_state", 16'(state), 16'd9);
      chk("beq0_pc_en", 16'(pc_en), 16'd0);
      cyc();
      chk("beq0_retired", retired, 16'd4);

      // Illegal opcode.
      opcode = 6'b111111;
      cyc();
      chk("ill_decode_state", 16'(state),   16'd2);
      chk("ill_pre_flag",     16'(illegal), 16'd0);
      cyc();
      chk("ill_next_state", 16'(state),   16'd1);
      chk("ill_flag",       16'(illegal), 16'd1);
      chk("ill_retired",    retired,      16'd4);

      // Ten jumps after the illegal opcode; the flag must persist.
      opcode = 6'b000010;
      cyc();
      cyc();
      chk("j_state", 16'(state), 16'd10);
      chk("j_pcsrc", 16'(pcsrc), 16'd2);
      chk("j_pc_en", 16'(pc_en), 16'd1);
      cyc();
      for (int i = 0; i < 9; i++) begin
         cyc();
         cyc();
         cyc();
      end
      chk("ill_sticky",     16'(illegal), 16'd1);
      chk("j10_retired",    retired,      16'd14);

      // SW; reset while MEMWR waits for ack.
      opcode = 6'b101011;
      cyc();
      mem_ack = 1'b0;
      cyc();
      cyc();
      chk("sw_memwr_state",    16'(state),    16'd6);
      chk("sw_memwr_memwrite", 16'(memwrite), 16'd1);
      cyc();
      chk("sw_hold_mem_req", 16'(mem_req), 16'd1);
      rst = 1'b1;
      #1;
      chk("async_state",    16'(state),    16'd0);
      chk("async_mem_req",  16'(mem_req),  16'd0);
      chk("async_memwrite", 16'(memwrite), 16'd0);
      chk("async_retired",  retired,       16'd0);
      chk("async_illegal",  16'(illegal),  16'd0);
      cyc();
      chk("rst_held_state", 16'(state), 16'd0);

      // Counter wrap: one J, then preload to 0xFFFF and retire one more.
      rst     = 1'b0;
      opcode  = 6'b000010;
      mem_ack = 1'b1;
      cyc();
      cyc();
      cyc();
      cyc();
      chk("wrap_pre_retired", retired, 16'd1);
      dut.retired_q = 16'hFFFF;
      cyc();
      cyc();
      chk("wrap_jump_state", 16'(state), 16'd10);
      cyc();
      chk("wrap_retired", retired, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
